sata_rx_prim_decode: RTL
========================

# sata_rx_prim_decode

Receive-side primitive decoder sitting directly downstream of the SATA PHY wrapper on each port. Consumes the per-port 32-bit receive dword and its K flag in the PHY clock domain, classifies each dword as a SATA primitive or payload, removes ALIGNs, expands CONT-compressed primitive streams, and tracks SOF/EOF framing. The link-layer FSM uses its registered outputs; one instance per port.

## Interface
- C_PRIM_W, 5, width of the primitive code output
- phyclk  in  1  PHY user clock; all logic on its rising edge
- phyreset  in  1  asynchronous, active-high reset
- linkup  in  1  PHY link established; low = synchronous flush to IDLE
- rxdata  in  32  received dword; byte0 is the K-character when rxdatak=1
- rxdatak  in  1  byte0 of rxdata is a K-character
- prim  out  C_PRIM_W  primitive code (PRIM_NONE when no primitive)
- prim_valid  out  1  prim holds a real or CONT-repeated primitive this cycle
- data  out  32  payload dword
- data_valid  out  1  data is a frame payload dword (between SOF and EOF)
- sof  out  1  one-cycle pulse with prim=PRIM_SOF
- eof  out  1  one-cycle pulse with prim=PRIM_EOF
- err_unknown  out  1  pulse: K dword that matches no primitive
- err_stray  out  1  pulse: non-K dword outside a frame and not under CONT

## Operation
- Recognized (hex, byte0 first): ALIGN 7B4A4ABC, SYNC B5B5957C, X_RDY 5757B57C, R_RDY 4A4A957C, R_IP 5555B57C, R_OK 3535B57C, R_ERR 5656B57C, SOF 3737B57C, EOF D5D5B57C, HOLD D5D5AA7C, HOLDA 9595AA7C, WTRM 5858B57C, CONT 9999AA7C, DMAT 3636B57C, PMREQ_P 1717B57C, PMREQ_S 7575957C, PMACK 9595957C, PMNAK F5F5957C.
- Match requires rxdatak=1 and exact 32-bit compare.
- ALIGN: never output; all outputs idle that cycle (prim_valid=0, data_valid=0); state and last_prim unchanged.
- States: IDLE, FRAME, IDLE_CONT, FRAME_CONT.
- IDLE: SOF -> FRAME; other primitive -> output, store in last_prim; CONT -> IDLE_CONT; non-K -> err_stray.
- FRAME: non-K -> data_valid; EOF -> IDLE; SOF -> err_unknown, stay FRAME; CONT -> FRAME_CONT; other primitives (HOLD, HOLDA, DMAT, SYNC...) -> prim_valid; SYNC also aborts frame -> IDLE.
- *_CONT: each cycle re-emit last_prim with prim_valid=1; non-K dwords discarded silently (no err_stray, no data_valid); further CONT ignored; new non-ALIGN primitive exits to IDLE/FRAME and is handled as in that state the same cycle.
- CONT with last_prim=PRIM_NONE (first after reset): enter CONT state but emit nothing.
- Unknown K dword: err_unknown pulse, prim=PRIM_UNKNOWN, prim_valid=0, state unchanged.
- linkup=0: state -> IDLE, last_prim -> PRIM_NONE, outputs idle next cycle.

## Timing
- All outputs registered; latency 1 phyclk from rxdata sample to output.
- Reset values: prim=PRIM_NONE, last_prim=PRIM_NONE, data=0, state=IDLE, all valid/pulse outputs 0.
- Reset or linkup drop mid-frame: frame abandoned; no eof generated.
- data holds last payload when data_valid=0; only data_valid qualifies it.
- sof/eof coincide with prim_valid=1; never with data_valid=1.
- Throughput: one dword per cycle, no backpressure.

## Structure
- Package sata_prim_pkg: 32-bit primitive constants, prim code enum (PRIM_NONE=0, PRIM_UNKNOWN, one per primitive), state enum.
- Sub-module sata_prim_lookup: combinational rxdata/rxdatak -> prim code; top holds FSM, last_prim and output registers.

## Test plan
- Reset, linkup=1, X_RDY x3 then SOF, 4 data dwords 11111111..44444444, EOF -> prim X_RDY x3, sof pulse, data_valid x4 with exact values, eof pulse; each 1 cycle after input.
- R_IP, R_IP, CONT, 6 random non-K dwords, ALIGN pair, SYNC -> R_IP repeated 9 cycles except idle for the 2 ALIGN cycles, then SYNC; no err_stray.
- In FRAME: data, HOLD, CONT, 3 junk dwords, data AAAA5555 (non-K) -> HOLD repeated through junk and AAAA5555 (discarded); next non-ALIGN primitive exits; confirm no data_valid for junk.
- K dword 12345678 with rxdatak=1 -> err_unknown pulse, prim_valid=0, state unchanged; non-K dword in IDLE -> err_stray pulse.
- Mid-frame linkup=0 one cycle, then data dword -> no data_valid, err_stray pulse; async phyreset mid-CONT -> all outputs 0 immediately, CONT after reset emits nothing.

Source files
------------

// File: rtl/sata_prim_pkg.sv
// Shared SATA receive primitive definitions: dword encodings, decoded primitive codes
// and the decoder's framing states.
package sata_prim_pkg;

  localparam int unsigned PRIM_CODE_W = 5;
  localparam int unsigned DWORD_W     = 32;

  // Primitive dwords as seen on the wire, byte0 (the K28.x character) in bits 7:0
  localparam logic [DWORD_W-1:0] P_ALIGN   = 32'h7B4A_4ABC;
  localparam logic [DWORD_W-1:0] P_SYNC    = 32'hB5B5_957C;
  localparam logic [DWORD_W-1:0] P_X_RDY   = 32'h5757_B57C;
  localparam logic [DWORD_W-1:0] P_R_RDY   = 32'h4A4A_957C;
  localparam logic [DWORD_W-1:0] P_R_IP    = 32'h5555_B57C;
  localparam logic [DWORD_W-1:0] P_R_OK    = 32'h3535_B57C;
  localparam logic [DWORD_W-1:0] P_R_ERR   = 32'h5656_B57C;
  localparam logic [DWORD_W-1:0] P_SOF     = 32'h3737_B57C;
  localparam logic [DWORD_W-1:0] P_EOF     = 32'hD5D5_B57C;
  localparam logic [DWORD_W-1:0] P_HOLD    = 32'hD5D5_AA7C;
  localparam logic [DWORD_W-1:0] P_HOLDA   = 32'h9595_AA7C;
  localparam logic [DWORD_W-1:0] P_WTRM    = 32'h5858_B57C;
  localparam logic [DWORD_W-1:0] P_CONT    = 32'h9999_AA7C;
  localparam logic [DWORD_W-1:0] P_DMAT    = 32'h3636_B57C;
  localparam logic [DWORD_W-1:0] P_PMREQ_P = 32'h1717_B57C;
  localparam logic [DWORD_W-1:0] P_PMREQ_S = 32'h7575_957C;
  localparam logic [DWORD_W-1:0] P_PMACK   = 32'h9595_957C;
  localparam logic [DWORD_W-1:0] P_PMNAK   = 32'hF5F5_957C;

  typedef enum logic [PRIM_CODE_W-1:0] {
    PRIM_NONE    = 5'd0,
    PRIM_UNKNOWN = 5'd1,
    PRIM_ALIGN   = 5'd2,
    PRIM_SYNC    = 5'd3,
    PRIM_X_RDY   = 5'd4,
    PRIM_R_RDY   = 5'd5,
    PRIM_R_IP    = 5'd6,
    PRIM_R_OK    = 5'd7,
    PRIM_R_ERR   = 5'd8,
    PRIM_SOF     = 5'd9,
    PRIM_EOF     = 5'd10,
    PRIM_HOLD    = 5'd11,
    PRIM_HOLDA   = 5'd12,
    PRIM_WTRM    = 5'd13,
    PRIM_CONT    = 5'd14,
    PRIM_DMAT    = 5'd15,
    PRIM_PMREQ_P = 5'd16,
    PRIM_PMREQ_S = 5'd17,
    PRIM_PMACK   = 5'd18,
    PRIM_PMNAK   = 5'd19
  } prim_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FRAME      = 2'd1,
    ST_IDLE_CONT  = 2'd2,
    ST_FRAME_CONT = 2'd3
  } state_e;

  // Frame-ness survives a CONT run so the exit primitive is handled in the right context
  function automatic logic is_frame_state(input state_e s);
    return (s == ST_FRAME) || (s == ST_FRAME_CONT);
  endfunction

  function automatic logic is_cont_state(input state_e s);
    return (s == ST_IDLE_CONT) || (s == ST_FRAME_CONT);
  endfunction

endpackage

// File: rtl/sata_prim_lookup.sv
// Combinational classifier: maps a received dword and its K flag to a primitive code.
// Non-K dwords give PRIM_NONE; K dwords with no exact match give PRIM_UNKNOWN.
module sata_prim_lookup
  import sata_prim_pkg::*;
(
  input  logic [DWORD_W-1:0] rxdata,
  input  logic               rxdatak,
  output prim_e              prim_c
);

  always_comb begin
    prim_c = PRIM_NONE;
    if (rxdatak) begin
      case (rxdata)
        P_ALIGN:   prim_c = PRIM_ALIGN;
        P_SYNC:    prim_c = PRIM_SYNC;
        P_X_RDY:   prim_c = PRIM_X_RDY;
        P_R_RDY:   prim_c = PRIM_R_RDY;
        P_R_IP:    prim_c = PRIM_R_IP;
        P_R_OK:    prim_c = PRIM_R_OK;
        P_R_ERR:   prim_c = PRIM_R_ERR;
        P_SOF:     prim_c = PRIM_SOF;
        P_EOF:     prim_c = PRIM_EOF;
        P_HOLD:    prim_c = PRIM_HOLD;
        P_HOLDA:   prim_c = PRIM_HOLDA;
        P_WTRM:    prim_c = PRIM_WTRM;
        P_CONT:    prim_c = PRIM_CONT;
        P_DMAT:    prim_c = PRIM_DMAT;
        P_PMREQ_P: prim_c = PRIM_PMREQ_P;
        P_PMREQ_S: prim_c = PRIM_PMREQ_S;
        P_PMACK:   prim_c = PRIM_PMACK;
        P_PMNAK:   prim_c = PRIM_PMNAK;
        default:   prim_c = PRIM_UNKNOWN;
      endcase
    end
  end

endmodule

// File: rtl/sata_rx_prim_decode.sv
// Per-port receive primitive decoder: drops ALIGN, expands CONT runs, tracks SOF/EOF
// framing and presents registered primitive/payload outputs to the link layer.
module sata_rx_prim_decode
  import sata_prim_pkg::*;
#(
  parameter int unsigned C_PRIM_W = PRIM_CODE_W
) (
  input  logic                phyclk,
  input  logic                phyreset,
  input  logic                linkup,
  input  logic [DWORD_W-1:0]  rxdata,
  input  logic                rxdatak,
  output logic [C_PRIM_W-1:0] prim,
  output logic                prim_valid,
  output logic [DWORD_W-1:0]  data,
  output logic                data_valid,
  output logic                sof,
  output logic                eof,
  output logic                err_unknown,
  output logic                err_stray
);

  prim_e              code_c;
  state_e             state_q, state_d;
  prim_e              last_prim_q, last_prim_d;
  prim_e              prim_d;
  logic               prim_valid_d;
  logic [DWORD_W-1:0] data_d;
  logic               data_valid_d;
  logic               sof_d;
  logic               eof_d;
  logic               err_unknown_d;
  logic               err_stray_d;
  logic               in_frame;
  logic               in_cont;

  sata_prim_lookup u_lookup (
    .rxdata  (rxdata),
    .rxdatak (rxdatak),
    .prim_c  (code_c)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d       = state_q;
    last_prim_d   = last_prim_q;
    prim_d        = PRIM_NONE;
    prim_valid_d  = 1'b0;
    data_d        = data;
    data_valid_d  = 1'b0;
    sof_d         = 1'b0;
    eof_d         = 1'b0;
    err_unknown_d = 1'b0;
    err_stray_d   = 1'b0;
    in_frame      = is_frame_state(state_q);
    in_cont       = is_cont_state(state_q);

    if (!linkup) begin
      state_d     = ST_IDLE;
      last_prim_d = PRIM_NONE;
    end else if (code_c == PRIM_ALIGN) begin
      // ALIGN is invisible: outputs idle, state and last_prim untouched
    end else if (code_c == PRIM_UNKNOWN) begin
      prim_d        = PRIM_UNKNOWN;
      err_unknown_d = 1'b1;
    end else if (code_c == PRIM_NONE) begin
      if (in_cont) begin
        // Scrambled filler under CONT stands for the last primitive
        prim_d       = last_prim_q;
        prim_valid_d = (last_prim_q != PRIM_NONE);
      end else if (in_frame) begin
        data_d       = rxdata;
        data_valid_d = 1'b1;
      end else begin
        err_stray_d = 1'b1;
      end
    end else if (code_c == PRIM_CONT) begin
      state_d      = in_frame ? ST_FRAME_CONT : ST_IDLE_CONT;
      prim_d       = last_prim_q;
      prim_valid_d = (last_prim_q != PRIM_NONE);
    end else if (in_frame) begin
      state_d = ST_FRAME;
      if (code_c == PRIM_SOF) begin
        // Nested SOF is a protocol violation; keep the current frame open
        prim_d        = PRIM_UNKNOWN;
        err_unknown_d = 1'b1;
      end else begin
        prim_d       = code_c;
        prim_valid_d = 1'b1;
        last_prim_d  = code_c;
        if (code_c == PRIM_EOF) begin
          eof_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (code_c == PRIM_SYNC) begin
          state_d = ST_IDLE;
        end
      end
    end else begin
      prim_d       = code_c;
      prim_valid_d = 1'b1;
      last_prim_d  = code_c;
      if (code_c == PRIM_SOF) begin
        sof_d   = 1'b1;
        state_d = ST_FRAME;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge phyclk or posedge phyreset) begin
    if (phyreset) begin
      state_q     <= ST_IDLE;
      last_prim_q <= PRIM_NONE;
      prim        <= C_PRIM_W'(PRIM_NONE);
      prim_valid  <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      err_unknown <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_prim_q <= last_prim_d;
      prim        <= C_PRIM_W'(prim_d);
      prim_valid  <= prim_valid_d;
      data        <= data_d;
      data_valid  <= data_valid_d;
      sof         <= sof_d;
      eof         <= eof_d;
      err_unknown <= err_unknown_d;
      err_stray   <= err_stray_d;
    end
  end

endmodule
